// File: rtl/adc_frame_capture_if.sv
// -----------------------------------------------------------------------------
// adc_frame_capture_if
// Bundles the ADC-side pins, the clk_ctrl toggles and the sample/bank outputs
// of adc_frame_capture.
//   master : drives drdy, dout, period_clr_tog, sync_req_tog; observes outputs
//   slave  : adc_frame_capture side
// -----------------------------------------------------------------------------
interface adc_frame_capture_if #(
    parameter int SAMPLE_W          = 24,
    parameter int FRAMES_PER_PERIOD = 8
);
    logic                                  drdy;
    logic                                  dout;
    logic                                  period_clr_tog;
    logic                                  sync_req_tog;
    logic                                  adc_sync_n;
    logic [SAMPLE_W-1:0]                   sample_data;
    logic [2:0]                            sample_idx;
    logic                                  sample_tog;
    logic [FRAMES_PER_PERIOD*SAMPLE_W-1:0] bank_flat;
    logic [FRAMES_PER_PERIOD-1:0]          bank_valid;
    logic                                  overrun;

    modport master (
        output drdy, dout, period_clr_tog, sync_req_tog,
        input  adc_sync_n, sample_data, sample_idx, sample_tog,
               bank_flat, bank_valid, overrun
    );

    modport slave (
        input  drdy, dout, period_clr_tog, sync_req_tog,
        output adc_sync_n, sample_data, sample_idx, sample_tog,
               bank_flat, bank_valid, overrun
    );
endinterface

// File: rtl/adc_frame_capture.sv
// -----------------------------------------------------------------------------
// adc_frame_capture
// Deserialises one SAMPLE_W-bit DOUT word per DRDY, banks up to
// FRAMES_PER_PERIOD samples per PWM period, publishes a per-sample toggle for
// CDC, and turns ADC sync requests into a timed active-low SYNC pulse.
// All logic runs on the falling edge of rst_dclk (ADC DCLK).
//   rst_dclk   : ADC DCLK
//   rst_ctrl   : async active-high reset, deassertion synchronised (2 flops)
//   bus.slave  : drdy/dout/toggles in; adc_sync_n, sample_*, bank_*, overrun out
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for drdy
// SHIFT    | shifting in SAMPLE_W bits of dout
// SYNC_LOW | adc_sync_n held low, counting SYNC_LOW_DCLKS
// BLANK    | drdy ignored for SYNC_BLANK_DCLKS after release
// -----------------------------------------------------------------------------
module adc_frame_capture #(
    parameter int SAMPLE_W          = 24,
    parameter int FRAMES_PER_PERIOD = 8,
    parameter int SYNC_LOW_DCLKS    = 4,
    parameter int SYNC_BLANK_DCLKS  = 32
) (
    input  logic                 rst_dclk,
    input  logic                 rst_ctrl,
    adc_frame_capture_if.slave   bus
);
    localparam int CNT_MAX = (SYNC_BLANK_DCLKS > SYNC_LOW_DCLKS) ? SYNC_BLANK_DCLKS : SYNC_LOW_DCLKS;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = $clog2(SAMPLE_W);
    localparam logic [3:0]       FRAMES_4   = 4'(FRAMES_PER_PERIOD);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(SAMPLE_W - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD   = CNT_W'(SYNC_LOW_DCLKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(SYNC_BLANK_DCLKS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, SYNC_LOW, BLANK} state_t;

    // Reset: asserts immediately, releases after two falling edges.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int;

    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    assign rst_int    = rst_sync_q[1];

    always_ff @(negedge rst_dclk or posedge rst_ctrl) begin
        if (rst_ctrl) rst_sync_q <= 2'b11;
        else          rst_sync_q <= rst_sync_d;
    end

    // Toggle synchronisers, bit 0 = period clear, bit 1 = sync request.
    logic [1:0] tog_meta_q, tog_meta_d;
    logic [1:0] tog_sync_q, tog_sync_d;
    logic [1:0] tog_last_q, tog_last_d;
    logic       clr_ev, sync_ev;

    assign tog_meta_d = {bus.sync_req_tog, bus.period_clr_tog};
    assign tog_sync_d = tog_meta_q;
    assign tog_last_d = tog_sync_q;
    assign clr_ev     = tog_sync_q[0] ^ tog_last_q[0];
    assign sync_ev    = tog_sync_q[1] ^ tog_last_q[1];

    always_ff @(negedge rst_dclk or posedge rst_int) begin
        if (rst_int) begin
            tog_meta_q <= '0;
            tog_sync_q <= '0;
            tog_last_q <= '0;
        end else begin
            tog_meta_q <= tog_meta_d;
            tog_sync_q <= tog_sync_d;
            tog_last_q <= tog_last_d;
        end
    end

    state_t              state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-2:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]    sync_cnt_q, sync_cnt_d;
    logic                adc_sync_n_q, adc_sync_n_d;
    logic [SAMPLE_W-1:0] sample_data_q, sample_data_d;
    logic [2:0]          sample_idx_q, sample_idx_d;
    logic                sample_tog_q, sample_tog_d;
    logic [SAMPLE_W-1:0] bank_q [FRAMES_PER_PERIOD];
    logic [SAMPLE_W-1:0] bank_d [FRAMES_PER_PERIOD];
    logic [FRAMES_PER_PERIOD-1:0] bank_valid_q, bank_valid_d;
    logic                overrun_q, overrun_d;
    logic [3:0]          wr_idx_q, wr_idx_d;

    logic [SAMPLE_W-1:0] word;
    logic                commit;
    logic [3:0]          wr_base;

    assign word = {shreg_q, bus.dout};

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        sync_cnt_d    = sync_cnt_q;
        adc_sync_n_d  = adc_sync_n_q;
        sample_data_d = sample_data_q;
        sample_idx_d  = sample_idx_q;
        sample_tog_d  = sample_tog_q;
        bank_d        = bank_q;
        commit        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.drdy) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                shreg_d   = word[SAMPLE_W-2:0];
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            SYNC_LOW: begin
                if (sync_cnt_q == '0) begin
                    adc_sync_n_d = 1'b1;
                    sync_cnt_d   = BLANK_LOAD;
                    state_d      = BLANK;
                end else begin
                    sync_cnt_d = sync_cnt_q - 1'b1;
                end
            end
            BLANK: begin
                if (sync_cnt_q == '0) state_d = IDLE;
                else                  sync_cnt_d = sync_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Sync overrides everything, including a commit on the same edge.
        if (sync_ev) begin
            commit       = 1'b0;
            state_d      = SYNC_LOW;
            adc_sync_n_d = 1'b0;
            sync_cnt_d   = LOW_LOAD;
        end

        // Period clear is applied before any commit on the same edge.
        wr_base      = clr_ev ? 4'd0 : wr_idx_q;
        wr_idx_d     = wr_base;
        bank_valid_d = clr_ev ? '0 : bank_valid_q;
        overrun_d    = clr_ev ? 1'b0 : overrun_q;

        if (commit) begin
            if (wr_base < FRAMES_4) begin
                bank_d[wr_base[2:0]]       = word;
                bank_valid_d[wr_base[2:0]] = 1'b1;
                sample_data_d              = word;
                sample_idx_d               = wr_base[2:0];
                sample_tog_d               = ~sample_tog_q;
                wr_idx_d                   = wr_base + 4'd1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(negedge rst_dclk or posedge rst_int) begin
        if (rst_int) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            sync_cnt_q    <= '0;
            adc_sync_n_q  <= 1'b1;
            sample_data_q <= '0;
            sample_idx_q  <= '0;
            sample_tog_q  <= 1'b0;
            bank_q        <= '{default: '0};
            bank_valid_q  <= '0;
            overrun_q     <= 1'b0;
            wr_idx_q      <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            sync_cnt_q    <= sync_cnt_d;
            adc_sync_n_q  <= adc_sync_n_d;
            sample_data_q <= sample_data_d;
            sample_idx_q  <= sample_idx_d;
            sample_tog_q  <= sample_tog_d;
            bank_q        <= bank_d;
            bank_valid_q  <= bank_valid_d;
            overrun_q     <= overrun_d;
            wr_idx_q      <= wr_idx_d;
        end
    end

    assign bus.adc_sync_n  = adc_sync_n_q;
    assign bus.sample_data = sample_data_q;
    assign bus.sample_idx  = sample_idx_q;
    assign bus.sample_tog  = sample_tog_q;
    assign bus.bank_valid  = bank_valid_q;
    assign bus.overrun     = overrun_q;

    for (genvar k = 0; k < FRAMES_PER_PERIOD; k++) begin : g_flat
        assign bus.bank_flat[k*SAMPLE_W +: SAMPLE_W] = bank_q[k];
    end
endmodule
